// File: rtl/conv_pkg.sv
// Shared state type, derived-size helpers and the output clamp used by the
// conv2d engine and its MAC/saturation stage.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_OUTPUT,
    ST_DONE
  } conv_state_e;

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic int acc_width(input int i_w, input int k);
    return 2 * i_w + $clog2(k * k);
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_I_WIDTH = 8;
  localparam int DEF_IMG_H   = 17;
  localparam int DEF_IMG_W   = 17;
  localparam int DEF_K       = 6;
  localparam int DEF_STRIDE  = 1;

  localparam int OH    = out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE);
  localparam int OW    = out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE);
  localparam int N_PIX = DEF_IMG_H * DEF_IMG_W;
  localparam int N_WGT = DEF_K * DEF_K;
  localparam int ACC_W = acc_width(DEF_I_WIDTH, DEF_K);

  // Optional ReLU, then clamp into the signed range of an o_w-bit result.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int o_w,
                                                  input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (o_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (o_w - 1));
    r  = (relu && (v < 64'sd0)) ? 64'sd0 : v;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv2d_engine_if.sv
// Load and result streams of the conv2d engine, grouped for port binding.
interface conv2d_engine_if #(parameter int BUS_W = 32);
  // Valid/ready: a word transfers on every cycle where valid and ready are both
  // high; the valid side keeps its data stable until that cycle.
  logic [BUS_W-1:0] i_data;
  logic             i_valid;
  logic             d_type;
  logic             i_ready;
  logic [BUS_W-1:0] o_data;
  logic             o_valid;
  logic             o_ready;

  modport master (output i_data, i_valid, d_type, o_ready,
                  input  i_ready, o_data, o_valid);
  modport slave  (input  i_data, i_valid, d_type, o_ready,
                  output i_ready, o_data, o_valid);
endinterface

// File: rtl/conv_mac_sat.sv
// Signed multiply-accumulate with an arithmetic-shift / ReLU / saturate output stage.
module conv_mac_sat
  import conv_pkg::*;
#(
  parameter int I_WIDTH = 8,
  parameter int ACC_W   = 22,
  parameter int SHIFT   = 8,
  parameter int O_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      first,
  input  logic                      relu,
  input  logic signed [I_WIDTH-1:0] pix,
  input  logic signed [I_WIDTH-1:0] wgt,
  output logic signed [O_WIDTH-1:0] res
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;

  assign prod = ACC_W'(pix) * ACC_W'(wgt);

  // The first tap of a position overwrites acc, so no separate clear cycle.
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (en) acc <= first ? prod : acc + prod;
  end

  assign res = O_WIDTH'(sat_relu(64'(acc >>> SHIFT), O_WIDTH, relu));

endmodule

// File: rtl/conv2d_engine.sv
// Single-channel 2-D convolution: buffered load, one MAC per cycle, stride,
// optional ReLU, shift + saturate, valid/ready result stream.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int I_WIDTH = 8,
  parameter int O_WIDTH = 8,
  parameter int IMG_H   = 17,
  parameter int IMG_W   = 17,
  parameter int K       = 6,
  parameter int STRIDE  = 1,
  parameter int SHIFT   = 8,
  parameter int BUS_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   relu_en,
  conv2d_engine_if.slave         bus,
  output logic                   busy,
  output logic                   finish,
  output conv_state_e            dbg_state
);

  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int NPIX  = IMG_H * IMG_W;
  localparam int NWGT  = K * K;
  localparam int ACCW  = acc_width(I_WIDTH, K);
  localparam int PA_W  = cnt_width(NPIX);
  localparam int WA_W  = cnt_width(NWGT);
  localparam int PC_W  = $clog2(NPIX + 1);
  localparam int WC_W  = $clog2(NWGT + 1);
  localparam int R_W   = cnt_width(OUT_H);
  localparam int C_W   = cnt_width(OUT_W);
  localparam int K_W   = cnt_width(K);

  conv_state_e st, st_nxt;
  logic relu_q;
  logic [PC_W-1:0] pix_cnt;
  logic [WC_W-1:0] wgt_cnt;
  logic [R_W-1:0]  orow;
  logic [C_W-1:0]  ocol;
  logic [K_W-1:0]  kr, kc;
  logic signed [I_WIDTH-1:0] pix_mem [NPIX];
  logic signed [I_WIDTH-1:0] wgt_mem [NWGT];
  logic pix_full, wgt_full, ld_acc, out_acc, last_tap, last_pos;
  logic [PA_W-1:0] pix_addr;
  logic [WA_W-1:0] wgt_addr;
  logic signed [O_WIDTH-1:0] res;
  logic unused_hi_bits;

  assign unused_hi_bits = ^bus.i_data[BUS_W-1:I_WIDTH];

  assign pix_full = (pix_cnt == PC_W'(NPIX));
  assign wgt_full = (wgt_cnt == WC_W'(NWGT));
  assign ld_acc   = bus.i_valid & bus.i_ready;
  assign out_acc  = bus.o_valid & bus.o_ready;
  assign last_tap = (kr == K_W'(K - 1)) && (kc == K_W'(K - 1));
  assign last_pos = (orow == R_W'(OUT_H - 1)) && (ocol == C_W'(OUT_W - 1));
  assign pix_addr = PA_W'((int'(orow) * STRIDE + int'(kr)) * IMG_W
                          + int'(ocol) * STRIDE + int'(kc));
  assign wgt_addr = WA_W'(int'(kr) * K + int'(kc));
  assign dbg_state = st;

  always_comb begin
    st_nxt      = st;
    bus.i_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_data  = '0;
    busy        = (st != ST_IDLE);
    finish      = 1'b0;
    case (st)
      ST_IDLE: begin
        bus.i_ready = start;
        if (start) st_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.i_ready = bus.d_type ? !wgt_full : !pix_full;
        if (pix_full && wgt_full) st_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (last_tap) st_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        bus.o_valid = 1'b1;
        bus.o_data  = {{(BUS_W-O_WIDTH){res[O_WIDTH-1]}}, res};
        if (bus.o_ready) st_nxt = last_pos ? ST_DONE : ST_COMPUTE;
      end
      ST_DONE: begin
        finish = 1'b1;
        st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
    if (rst) bus.i_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      relu_q  <= 1'b0;
      pix_cnt <= '0;
      wgt_cnt <= '0;
      orow    <= '0;
      ocol    <= '0;
      kr      <= '0;
      kc      <= '0;
    end else begin
      st <= st_nxt;
      if (st == ST_IDLE && start) relu_q <= relu_en;
      if (ld_acc) begin
        if (bus.d_type) wgt_cnt <= wgt_cnt + WC_W'(1);
        else            pix_cnt <= pix_cnt + PC_W'(1);
      end
      // Counters rewind at job end so the start-cycle word lands at index 0.
      if (st == ST_DONE) begin
        pix_cnt <= '0;
        wgt_cnt <= '0;
      end
      if (st == ST_COMPUTE) begin
        if (kc == K_W'(K - 1)) begin
          kc <= '0;
          kr <= (kr == K_W'(K - 1)) ? '0 : kr + K_W'(1);
        end else begin
          kc <= kc + K_W'(1);
        end
      end
      if (out_acc) begin
        if (ocol == C_W'(OUT_W - 1)) begin
          ocol <= '0;
          orow <= (orow == R_W'(OUT_H - 1)) ? '0 : orow + R_W'(1);
        end else begin
          ocol <= ocol + C_W'(1);
        end
      end
    end
  end

  // Buffer contents need no reset; counters decide what is valid.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      if (bus.d_type) wgt_mem[WA_W'(wgt_cnt)] <= bus.i_data[I_WIDTH-1:0];
      else            pix_mem[PA_W'(pix_cnt)] <= bus.i_data[I_WIDTH-1:0];
    end
  end

  conv_mac_sat #(
    .I_WIDTH (I_WIDTH),
    .ACC_W   (ACCW),
    .SHIFT   (SHIFT),
    .O_WIDTH (O_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en    (st == ST_COMPUTE),
    .first ((kr == '0) && (kc == '0)),
    .relu  (relu_q),
    .pix   (pix_mem[pix_addr]),
    .wgt   (wgt_mem[wgt_addr]),
    .res   (res)
  );

endmodule
